// File: rtl/nco_clkgen_pkg.sv
// Shared types and helpers for the multi-channel NCO clock-enable generator.
package nco_clkgen_pkg;

  typedef enum logic {
    S_LOCKING = 1'b0,
    S_LOCKED  = 1'b1
  } state_t;

  // Index width for an n-entry range, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nco_clkgen_multi_if.sv
// Configuration bus for nco_clkgen_multi: shadow writes, commit, align, relock, error pulse.
interface nco_clkgen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32
) ();
  localparam int CH_W = nco_clkgen_pkg::clog2_min1(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_update;
  logic             cfg_align;
  logic             cfg_relock;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_inc, cfg_update, cfg_align, cfg_relock,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_inc, cfg_update, cfg_align, cfg_relock,
    output cfg_err
  );
endinterface

// File: rtl/nco_channel.sv
// One NCO channel: shadow/active increment pair, phase accumulator, registered clk_out and tick.
module nco_channel #(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic             update,
  input  logic             active,
  input  logic             run,
  input  logic             relock,
  input  logic             align,
  output logic             clk_out,
  output logic             tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] act_inc;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, act_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the increment registers are reset too, because DEFAULT_INC is the
      // rate every channel must run at before software programs anything.
      acc     <= '0;
      act_inc <= DEFAULT_INC;
      shadow  <= DEFAULT_INC;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (wr_en) shadow <= wr_inc;
      // NOTE: non-blocking assignment means a commit in the same cycle as a
      // write copies the old shadow; the new value waits for the next commit.
      if (update) act_inc <= shadow;

      if (relock) begin
        acc     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (!active) begin
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (align) begin
        acc     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (run) begin
        acc     <= sum[ACC_W-1:0];
        clk_out <= sum[ACC_W-1];
        tick    <= sum[ACC_W];
      end else begin
        // Disabled channel keeps its phase so it resumes where it stopped.
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nco_clkgen_multi.sv
// Multi-channel programmable NCO clock-enable generator: lock FSM, config decode, channel array.
module nco_clkgen_multi
  import nco_clkgen_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               ACC_W       = 32,
  parameter int               LOCK_DELAY  = 64,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(1082331758)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_en,
  nco_clkgen_multi_if.slave   cfg,
  output logic                locked,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
);

  localparam int CH_W   = clog2_min1(NUM_CH);
  localparam int LCNT_W = clog2_min1(LOCK_DELAY);

  state_t            state;
  logic [LCNT_W-1:0] lock_cnt;
  logic              is_locked;
  logic              ch_valid;
  logic              relock_fire;
  logic              align_fire;

  assign is_locked   = (state == S_LOCKED);
  assign ch_valid    = ({1'b0, cfg.cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign relock_fire = is_locked && cfg.cfg_relock;
  assign align_fire  = is_locked && cfg.cfg_align;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOCKING;
      lock_cnt    <= '0;
      locked      <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= cfg.cfg_we && !ch_valid;
      case (state)
        S_LOCKING: begin
          if (lock_cnt == LCNT_W'(LOCK_DELAY - 1)) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        S_LOCKED: begin
          if (cfg.cfg_relock) begin
            state    <= S_LOCKING;
            lock_cnt <= '0;
            locked   <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nco_channel #(
      .ACC_W       (ACC_W),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))),
      .wr_inc  (cfg.cfg_inc),
      .update  (cfg.cfg_update),
      .active  (is_locked),
      .run     (ch_en[i]),
      .relock  (relock_fire),
      .align   (align_fire),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_nco_clkgen_multi.sv
// Scoreboard bench for nco_clkgen_multi: directed stimulus pushes expectations, a monitor compares.
module tb_nco_clkgen_multi;

  // Five channels so that a 3-bit channel index can address a non-existent channel (5).
  localparam int NUM_CH     = 5;
  localparam int ACC_W      = 32;
  localparam int LOCK_DELAY = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              locked;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  nco_clkgen_multi_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg_if ();

  nco_clkgen_multi #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_DELAY (LOCK_DELAY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ch_en   (ch_en),
    .cfg     (cfg_if),
    .locked  (locked),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  typedef enum {K_LOCKED, K_ERR, K_CLK, K_TICK, K_CLKV, K_TICKV} kind_t;
  typedef struct {
    int                tag;
    kind_t             kind;
    int                ch;
    logic [NUM_CH-1:0] val;
    string             name;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_vec    = 0;
  int   n_bad    = 0;

  // Quarter-rate pattern (0x4000_0000 or DEFAULT_INC from zero) and half-rate pattern.
  bit q_clk[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit q_tick[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  bit h_clk[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit h_tick[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    exp_t              e;
    logic [NUM_CH-1:0] act;
    while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
      e = sb.pop_front();
      case (e.kind)
        K_LOCKED: act = NUM_CH'(locked);
        K_ERR:    act = NUM_CH'(cfg_if.cfg_err);
        K_CLK:    act = NUM_CH'(clk_out[e.ch]);
        K_TICK:   act = NUM_CH'(tick[e.ch]);
        K_CLKV:   act = clk_out;
        default:  act = tick;
      endcase
      n_vec++;
      if (e.tag != edge_cnt || act !== e.val) begin
        n_bad++;
        $display("FAIL %s edge=%0d (sampled at %0d) got=%b exp=%b",
                 e.name, e.tag, edge_cnt, act, e.val);
      end
    end
  end

  task automatic exp_push(kind_t k, int ch, logic [NUM_CH-1:0] v, string name);
    exp_t e;
    e.tag  = edge_cnt;
    e.kind = k;
    e.ch   = ch;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk_ch(int ch, bit c, bit t, string name);
    exp_push(K_CLK,  ch, NUM_CH'(c), {name, "_clk"});
    exp_push(K_TICK, ch, NUM_CH'(t), {name, "_tick"});
  endtask

  task automatic chk_quiet(string name);
    exp_push(K_CLKV,  0, '0, {name, "_clkv"});
    exp_push(K_TICKV, 0, '0, {name, "_tickv"});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    ch_en             = '1;
    cfg_if.cfg_we     = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_inc    = '0;
    cfg_if.cfg_update = 1'b0;
    cfg_if.cfg_align  = 1'b0;
    cfg_if.cfg_relock = 1'b0;

    // 1: reset state and lock timing, channels enabled but gated until lock.
    step();
    step();
    exp_push(K_LOCKED, 0, '0, "rst_locked");
    exp_push(K_ERR,    0, '0, "rst_err");
    chk_quiet("rst");
    rst = 1'b0;
    for (int k = 1; k <= LOCK_DELAY; k++) begin
      step();
      exp_push(K_LOCKED, 0, NUM_CH'(k == LOCK_DELAY), "lock_seq");
      chk_quiet("lock_gate");
    end
    ch_en = '0;

    // 2: ch0 at quarter rate via write then commit (align zeroes the phases).
    cfg_if.cfg_we  = 1'b1;
    cfg_if.cfg_ch  = 3'd0;
    cfg_if.cfg_inc = 32'h4000_0000;
    step();
    cfg_if.cfg_we = 1'b0;
    exp_push(K_ERR, 0, '0, "t2_valid_we_err");
    chk_quiet("t2_disabled");
    cfg_if.cfg_update = 1'b1;
    cfg_if.cfg_align  = 1'b1;
    step();
    cfg_if.cfg_update = 1'b0;
    cfg_if.cfg_align  = 1'b0;
    ch_en = 5'b00001;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_ch(0, q_clk[i % 4], q_tick[i % 4], "t2_ch0");
    end
    ch_en = '0;

    // 3: write ch1 with commit in the same cycle -> still DEFAULT_INC; later commit switches.
    cfg_if.cfg_we     = 1'b1;
    cfg_if.cfg_ch     = 3'd1;
    cfg_if.cfg_inc    = 32'h8000_0000;
    cfg_if.cfg_update = 1'b1;
    step();
    cfg_if.cfg_we     = 1'b0;
    cfg_if.cfg_update = 1'b0;
    exp_push(K_ERR, 0, '0, "t3_err");
    ch_en = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ch(1, q_clk[i], q_tick[i], "t3_old_rate");
    end
    cfg_if.cfg_update = 1'b1;
    step();
    cfg_if.cfg_update = 1'b0;
    chk_ch(1, 1'b0, 1'b0, "t3_commit_edge");   // acc1 = 0x428F_5C26
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ch(1, h_clk[i], h_tick[i], "t3_new_rate");
    end

    // 4: out-of-range channel write: error pulse, ch1 (index alias) untouched.
    cfg_if.cfg_we  = 1'b1;
    cfg_if.cfg_ch  = 3'd5;
    cfg_if.cfg_inc = 32'h0000_1234;
    step();
    cfg_if.cfg_we = 1'b0;
    exp_push(K_ERR, 0, NUM_CH'(1'b1), "t4_err_pulse");
    chk_ch(1, 1'b1, 1'b0, "t4_ch1_a");
    cfg_if.cfg_update = 1'b1;
    step();
    cfg_if.cfg_update = 1'b0;
    exp_push(K_ERR, 0, '0, "t4_err_clear");
    chk_ch(1, 1'b0, 1'b1, "t4_ch1_b");
    step();
    chk_ch(1, 1'b1, 1'b0, "t4_ch1_c");
    step();
    chk_ch(1, 1'b0, 1'b1, "t4_ch1_d");

    // 5: two rates, then align resets both phases on one edge.
    ch_en = 5'b00011;
    step(); chk_ch(0, 1'b0, 1'b0, "t5_pre0"); chk_ch(1, 1'b1, 1'b0, "t5_pre1");
    step(); chk_ch(0, 1'b1, 1'b0, "t5_pre0"); chk_ch(1, 1'b0, 1'b1, "t5_pre1");
    step(); chk_ch(0, 1'b1, 1'b0, "t5_pre0"); chk_ch(1, 1'b1, 1'b0, "t5_pre1");
    cfg_if.cfg_align = 1'b1;
    step();
    cfg_if.cfg_align = 1'b0;
    chk_ch(0, 1'b0, 1'b0, "t5_align0");
    chk_ch(1, 1'b0, 1'b0, "t5_align1");
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ch(0, q_clk[i], q_tick[i], "t5_fresh0");
      chk_ch(1, h_clk[i], h_tick[i], "t5_fresh1");
    end

    // 6: relock mid-run (relock during locking ignored), then reset during locking.
    ch_en = '1;
    step(); chk_ch(1, 1'b1, 1'b0, "t6_run1");
    cfg_if.cfg_relock = 1'b1;
    step();
    cfg_if.cfg_relock = 1'b0;
    exp_push(K_LOCKED, 0, '0, "t6_relock_locked");
    chk_quiet("t6_relock");
    for (int k = 1; k <= LOCK_DELAY; k++) begin
      if (k == 10) cfg_if.cfg_relock = 1'b1;
      step();
      cfg_if.cfg_relock = 1'b0;
      exp_push(K_LOCKED, 0, NUM_CH'(k == LOCK_DELAY), "t6_relock_seq");
      chk_quiet("t6_relock_gate");
    end
    step();
    chk_ch(0, 1'b0, 1'b0, "t6_kept0");
    chk_ch(1, 1'b1, 1'b0, "t6_kept1");
    cfg_if.cfg_relock = 1'b1;
    step();
    cfg_if.cfg_relock = 1'b0;
    chk_quiet("t6_relock2");
    repeat (3) begin
      step();
      exp_push(K_LOCKED, 0, '0, "t6_locking");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_push(K_LOCKED, 0, '0, "t6_rst_locked");
    chk_quiet("t6_rst");
    for (int k = 1; k <= LOCK_DELAY; k++) begin
      step();
      exp_push(K_LOCKED, 0, NUM_CH'(k == LOCK_DELAY), "t6_rst_seq");
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ch(1, q_clk[i], q_tick[i], "t6_default1");
      chk_ch(2, q_clk[i], q_tick[i], "t6_default2");
    end

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
